// File: rtl/uart_tx_block.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out start / 8 data LSB-first / [parity] / stop.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_block #(
  parameter int BIT_PERIOD = 10,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_renable,
  input  logic       tx_enable,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int            TW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_out_q, serial_out_d;
  logic          tx_busy_q, tx_busy_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic bit_end;
  logic pop_ok;

  // The pop strobe is gated by n_rst so the FIFO is never drained while held in reset.
  assign bit_end = (timer_q == TIMER_LAST);
  assign pop_ok  = n_rst & tx_enable & ~fifo_empty;

  // Next-state, pop strobe and frame_done decode.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    fifo_renable = 1'b0;
    frame_done   = 1'b0;

    if (state_q == IDLE) begin
      timer_d = TIMER_ZERO;
    end else if (bit_end) begin
      timer_d = TIMER_ZERO;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (pop_ok) begin
          fifo_renable = 1'b1;
          shift_d      = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d     = even_parity(fifo_rdata);
`endif
          state_d      = START;
          bit_cnt_d    = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            frame_done = 1'b1;
            bit_cnt_d  = 3'd0;
            // Back-to-back: the next byte is taken in the very last stop cycle.
            if (pop_ok) begin
              fifo_renable = 1'b1;
              shift_d      = fifo_rdata;
`ifdef UART_TX_PARITY_EN
              parity_d     = even_parity(fifo_rdata);
`endif
              state_d      = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Line level and busy flag for the upcoming cycle, so both outputs are registered.
  always_comb begin
    case (state_d)
      IDLE:    serial_out_d = 1'b1;
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_out_d = parity_d;
`endif
      STOP:    serial_out_d = 1'b1;
      default: serial_out_d = 1'b1;
    endcase
    tx_busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset forces the line high immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      timer_q      <= TIMER_ZERO;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      serial_out_q <= 1'b1;
      tx_busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      tx_busy_q    <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign serial_out = serial_out_q;
  assign tx_busy    = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Self-checking bench for uart_tx_block: FIFO model plus a queue of expected line levels per clock.
`timescale 1ns/1ps
module tb_uart_tx_block;

  localparam int BP = 10;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_LEN = (10 + SB - 1 + PB) * BP;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'd0;
  logic       fifo_renable;
  logic       tx_enable = 1'b1;
  logic       serial_out;
  logic       tx_busy;
  logic       frame_done;

  always #5 clk = ~clk;

  uart_tx_block #(.BIT_PERIOD(BP), .STOP_BITS(SB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_renable (fifo_renable),
    .tx_enable    (tx_enable),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy),
    .frame_done   (frame_done)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pop_cyc = -1;
  int   busy_cnt = 0;
  int   n_pops = 0;
  bit   mask = 1'b0;
  logic [7:0] fq[$];
  bit   line_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0) || mask;
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'($urandom);
  endtask

  // Expected line level for every clock of one frame carrying byte b.
  task automatic add_frame(input logic [7:0] b);
    repeat (BP) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (BP) line_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (BP) line_q.push_back(^b);
`endif
    repeat (SB * BP) line_q.push_back(1'b1);
  endtask

  task automatic cycle();
    bit         exp_pop;
    logic [7:0] b;
    drive_fifo();
    @(negedge clk);
    cyc++;
    if (!n_rst) begin
      check_eq("rst_serial_out", serial_out, 1'b1);
      check_eq("rst_tx_busy", tx_busy, 1'b0);
      check_eq("rst_renable", fifo_renable, 1'b0);
      check_eq("rst_frame_done", frame_done, 1'b0);
      line_q.delete();
      pop_cyc = -1;
    end else begin
      exp_pop = (line_q.size() <= 1) && tx_enable && !fifo_empty;
      check_eq("serial_out", serial_out, (line_q.size() != 0) ? line_q[0] : 1'b1);
      check_eq("tx_busy", tx_busy, line_q.size() != 0);
      check_eq("frame_done", frame_done, line_q.size() == 1);
      check_eq("fifo_renable", fifo_renable, exp_pop);
      if (frame_done === 1'b1 && pop_cyc >= 0) check_eq("done_latency", cyc - pop_cyc, FRAME_LEN);
      if (fifo_renable === 1'b1) begin
        pop_cyc = cyc;
        n_pops++;
      end
      if (tx_busy === 1'b1) busy_cnt++;
      if (line_q.size() != 0) void'(line_q.pop_front());
      if (exp_pop) begin
        b = fq.pop_front();
        add_frame(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((line_q.size() != 0 || tx_busy === 1'b1 || (fq.size() != 0 && tx_enable && !mask)) && n < bound);
    if (n >= bound) check_eq("idle_timeout", tx_busy, 1'b0);
  endtask

  initial begin
    #1 n_rst = 1'b0;

    // Reset held while the FIFO already has data.
    fq.push_back(8'hA5);
    repeat (3) cycle();
    n_rst = 1'b1;
    n_pops = 0;
    wait_idle(FRAME_LEN + 20);
    check_eq("pops_a5", n_pops, 1);

    // Two queued bytes go out back to back.
    n_pops = 0;
    busy_cnt = 0;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    wait_idle(2 * FRAME_LEN + 20);
    check_eq("busy_b2b", busy_cnt, 2 * FRAME_LEN);
    check_eq("pops_b2b", n_pops, 2);

`ifdef UART_TX_PARITY_EN
    fq.push_back(8'h07);
    fq.push_back(8'hA5);
    wait_idle(2 * FRAME_LEN + 20);
`endif

    // tx_enable dropped at the 5th data bit with another byte queued.
    fq.push_back(8'h96);
    fq.push_back(8'h69);
    cycle();
    repeat (5 * BP) cycle();
    tx_enable = 1'b0;
    n_pops = 0;
    repeat (2 * FRAME_LEN) cycle();
    check_eq("pops_disabled", n_pops, 0);
    tx_enable = 1'b1;
    wait_idle(FRAME_LEN + 20);
    check_eq("pops_reenabled", n_pops, 1);

    // Reset pulsed during data bit 3 of 0x3C.
    fq.push_back(8'h3C);
    fq.push_back(8'h5A);
    cycle();
    repeat (4 * BP + 3) cycle();
    n_rst = 1'b0;
    #1;
    check_eq("async_serial_out", serial_out, 1'b1);
    check_eq("async_tx_busy", tx_busy, 1'b0);
    repeat (2) cycle();
    n_rst = 1'b1;
    n_pops = 0;
    wait_idle(FRAME_LEN + 20);
    check_eq("pops_after_reset", n_pops, 1);

    // Random traffic with FIFO pushes, enable toggles and masked empty flag.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) fq.push_back(8'($urandom));
      tx_enable = ($urandom_range(0, 7) != 0);
      mask = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(1, 60)) cycle();
    end
    tx_enable = 1'b1;
    mask = 1'b0;
    wait_idle((fq.size() + 2) * FRAME_LEN + 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
